// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU-side and SRAM-side signals around the shared memory port.
// "slave" is the arbiter's view; "master" is the surrounding CPU/SRAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  im_req;
  logic [ADDR_W-1:0]     im_addr;
  logic                  im_gnt;
  logic                  im_rvalid;
  logic [DATA_W-1:0]     im_rdata;

  logic                  dm_req;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W/8-1:0]   dm_web;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  sram_cs;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W/8-1:0]   sram_web;
  logic [DATA_W-1:0]     sram_wdata;
  logic [DATA_W-1:0]     sram_rdata;

  modport slave (
    input  im_req, im_addr, dm_req, dm_addr, dm_web, dm_wdata, sram_rdata,
    output im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
           sram_cs, sram_addr, sram_web, sram_wdata
  );

  modport master (
    output im_req, im_addr, dm_req, dm_addr, dm_web, dm_wdata, sram_rdata,
    input  im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
           sram_cs, sram_addr, sram_web, sram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port SRAM between instruction fetch (IM) and
// load/store (DM). DM has fixed priority; IM is promoted for one grant after
// STARVE_LIMIT consecutive denials. Read data returns one cycle after the
// grant, tagged to whichever requester issued the read.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);
  localparam int         IdxIm       = 0;
  localparam int         IdxDm       = 1;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [1:0] rd_owner_q, rd_owner_d;
  logic       im_prio;
  logic       im_gnt;
  logic       dm_gnt;
  logic       dm_is_read;

  // Grant decision: DM wins unless IM is both requesting and promoted; reset blocks all grants.
  always_comb begin
    im_prio    = (starve_cnt_q >= StarveLimit);
    dm_is_read = (bus.dm_web == '0);
    dm_gnt     = 1'b0;
    im_gnt     = 1'b0;
    if (!rst) begin
      if (bus.dm_req && !(bus.im_req && im_prio)) begin
        dm_gnt = 1'b1;
      end else if (bus.im_req) begin
        im_gnt = 1'b1;
      end
    end
  end

  // Drive the SRAM from the granted requester; an idle port presents all zeros.
  always_comb begin
    bus.sram_cs    = im_gnt | dm_gnt;
    bus.sram_addr  = '0;
    bus.sram_web   = '0;
    bus.sram_wdata = '0;
    if (dm_gnt) begin
      bus.sram_addr  = bus.dm_addr;
      bus.sram_web   = bus.dm_web;
      bus.sram_wdata = bus.dm_wdata;
    end else if (im_gnt) begin
      bus.sram_addr  = bus.im_addr;
    end
  end

  // Next-state for read ownership and the saturating IM starvation counter.
  always_comb begin
    rd_owner_d = '0;
    rd_owner_d[IdxDm] = dm_gnt && dm_is_read;
    rd_owner_d[IdxIm] = im_gnt;
    if (im_gnt || !bus.im_req) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= 2'b00;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Return path: a read issued just before reset must not surface, so valids are masked by rst.
  always_comb begin
    bus.im_gnt    = im_gnt;
    bus.dm_gnt    = dm_gnt;
    bus.im_rvalid = rd_owner_q[IdxIm] && !rst;
    bus.dm_rvalid = rd_owner_q[IdxDm] && !rst;
    bus.im_rdata  = bus.im_rvalid ? bus.sram_rdata : '0;
    bus.dm_rdata  = bus.dm_rvalid ? bus.sram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, a STARVE_LIMIT=0 instance,
// and constrained-random traffic checked against a behavioural model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut0 (
    .clk(clk), .rst(rst), .bus(bif0.slave)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1.slave)
  );

  typedef struct {
    logic        rst;
    logic        imReq;
    logic [31:0] imAddr;
    logic        dmReq;
    logic [31:0] dmAddr;
    logic [3:0]  dmWeb;
    logic [31:0] dmWdata;
    logic        eIm;
    logic        eDm;
    logic        eImRv;
    logic        eDmRv;
  } vec_t;

  vec_t vecs[$];

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] sramMem [0:255];
  logic [31:0] refMem  [0:255];

  int          denied;
  bit          pendIm, pendDm;
  logic [31:0] pendImData, pendDmData;

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] web);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (web[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic vec_t mkVec(input logic r, input logic iq, input logic [31:0] ia,
                                 input logic dq, input logic [31:0] da, input logic [3:0] dw,
                                 input logic [31:0] dd, input logic ei, input logic ed,
                                 input logic eri, input logic erd);
    vec_t v;
    v.rst = r; v.imReq = iq; v.imAddr = ia; v.dmReq = dq; v.dmAddr = da;
    v.dmWeb = dw; v.dmWdata = dd; v.eIm = ei; v.eDm = ed; v.eImRv = eri; v.eDmRv = erd;
    return v;
  endfunction

  // SRAM model for the main instance: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (bif0.sram_cs) begin
      if (bif0.sram_web == 4'b0) bif0.sram_rdata <= sramMem[bif0.sram_addr[9:2]];
      else sramMem[bif0.sram_addr[9:2]] <= mergeBytes(sramMem[bif0.sram_addr[9:2]],
                                                       bif0.sram_wdata, bif0.sram_web);
    end
  end

  // Trivial SRAM for the STARVE_LIMIT=0 instance: data is a function of last cycle's address.
  always @(posedge clk) begin
    bif1.sram_rdata <= bif1.sram_addr ^ 32'h5A5A_5A5A;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst           = v.rst;
    bif0.im_req   = v.imReq;
    bif0.im_addr  = v.imAddr;
    bif0.dm_req   = v.dmReq;
    bif0.dm_addr  = v.dmAddr;
    bif0.dm_web   = v.dmWeb;
    bif0.dm_wdata = v.dmWdata;
  endtask

  // Apply one cycle of stimulus (caller is at a negedge), check, then advance the model.
  task automatic stepDut0(input vec_t v, input bit useTable, output bit gIm, output bit gDm);
    logic        eIm, eDm, eRvI, eRvD;
    logic [31:0] eAddr, eWd;
    logic [3:0]  eWeb;
    applyStimulus(v);
    #2;
    if (v.rst) begin
      eIm = 0; eDm = 0; eRvI = 0; eRvD = 0;
    end else begin
      eDm  = v.dmReq && !(v.imReq && denied >= LIMIT);
      eIm  = v.imReq && !eDm;
      eRvI = pendIm;
      eRvD = pendDm;
    end
    eAddr = eDm ? v.dmAddr  : (eIm ? v.imAddr : 32'h0);
    eWeb  = eDm ? v.dmWeb   : 4'h0;
    eWd   = eDm ? v.dmWdata : 32'h0;

    checkOutput("im_gnt",     bif0.im_gnt,     eIm);
    checkOutput("dm_gnt",     bif0.dm_gnt,     eDm);
    checkOutput("sram_cs",    bif0.sram_cs,    eIm | eDm);
    checkOutput("sram_addr",  bif0.sram_addr,  eAddr);
    checkOutput("sram_web",   bif0.sram_web,   eWeb);
    checkOutput("sram_wdata", bif0.sram_wdata, eWd);
    checkOutput("im_rvalid",  bif0.im_rvalid,  eRvI);
    checkOutput("dm_rvalid",  bif0.dm_rvalid,  eRvD);
    checkOutput("im_rdata",   bif0.im_rdata,   eRvI ? pendImData : 32'h0);
    checkOutput("dm_rdata",   bif0.dm_rdata,   eRvD ? pendDmData : 32'h0);

    if (useTable) begin
      checkOutput("tbl_im_gnt",    bif0.im_gnt,    v.eIm);
      checkOutput("tbl_dm_gnt",    bif0.dm_gnt,    v.eDm);
      checkOutput("tbl_im_rvalid", bif0.im_rvalid, v.eImRv);
      checkOutput("tbl_dm_rvalid", bif0.dm_rvalid, v.eDmRv);
    end

    if (v.rst) begin
      denied = 0; pendIm = 0; pendDm = 0;
    end else begin
      pendIm = eIm;
      if (eIm) pendImData = refMem[v.imAddr[9:2]];
      pendDm = eDm && (v.dmWeb == 4'h0);
      if (pendDm) pendDmData = refMem[v.dmAddr[9:2]];
      if (eDm && v.dmWeb != 4'h0)
        refMem[v.dmAddr[9:2]] = mergeBytes(refMem[v.dmAddr[9:2]], v.dmWdata, v.dmWeb);
      if (eIm || !v.imReq) denied = 0;
      else if (denied < 15) denied++;
    end
    gIm = eIm;
    gDm = eDm;
  endtask

  initial begin
    vec_t        idle, v;
    bit          gI, gD, imHeld, dmHeld;
    logic [31:0] prevAddr, hi;

    for (int i = 0; i < 256; i++) begin
      sramMem[i] = initWord(32'(i) << 2);
      refMem[i]  = initWord(32'(i) << 2);
    end
    denied = 0; pendIm = 0; pendDm = 0; pendImData = '0; pendDmData = '0;
    rst = 1'b1;
    bif0.im_req = 0; bif0.im_addr = '0; bif0.dm_req = 0; bif0.dm_addr = '0;
    bif0.dm_web = '0; bif0.dm_wdata = '0;
    bif1.im_req = 0; bif1.im_addr = '0; bif1.dm_req = 0; bif1.dm_addr = '0;
    bif1.dm_web = '0; bif1.dm_wdata = '0;
    idle = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset, then IM-only burst and a DM/IM collision.
    vecs.push_back(mkVec(1, 0, 32'h0,   0, 32'h0,   4'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 1, 32'h0,   1, 32'h100, 4'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 32'h0,   0, 32'h0,   4'h0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 32'h4,   0, 32'h0,   4'h0, 0, 1, 0, 1, 0));
    vecs.push_back(mkVec(0, 1, 32'h8,   0, 32'h0,   4'h0, 0, 1, 0, 1, 0));
    vecs.push_back(mkVec(0, 1, 32'h0,   1, 32'h100, 4'h0, 0, 0, 1, 1, 0));
    vecs.push_back(mkVec(0, 1, 32'h0,   0, 32'h0,   4'h0, 0, 1, 0, 0, 1));
    vecs.push_back(mkVec(0, 0, 32'h0,   0, 32'h0,   4'h0, 0, 0, 0, 1, 0));
    // Continuous DM traffic against a held IM request: IM wins in cycles 4 and 9.
    for (int c = 0; c < 10; c++) begin
      bit imW;
      imW = (c == 4) || (c == 9);
      vecs.push_back(mkVec(0, 1, 32'hC, 1, 32'h300, 4'h0, 0, imW, !imW,
                           (c == 5), (c != 0 && c != 5)));
    end
    vecs.push_back(mkVec(0, 0, 32'h0,   0, 32'h0,   4'h0, 0, 0, 0, 1, 0));
    // Partial write then read-back.
    vecs.push_back(mkVec(0, 0, 32'h0,   1, 32'h200, 4'h3, 32'hDEADBEEF, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 0, 32'h0,   1, 32'h200, 4'h0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 0, 32'h0,   0, 32'h0,   4'h0, 0, 0, 0, 0, 1));
    // IM read followed immediately by reset.
    vecs.push_back(mkVec(0, 1, 32'h10,  0, 32'h0,   4'h0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 1, 32'h10,  1, 32'h100, 4'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 0, 32'h0,   0, 32'h0,   4'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 32'h0,   0, 32'h0,   4'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 32'h14,  1, 32'h100, 4'h0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 32'h14,  0, 32'h0,   4'h0, 0, 1, 0, 0, 1));
    vecs.push_back(mkVec(0, 0, 32'h0,   0, 32'h0,   4'h0, 0, 0, 0, 1, 0));

    $display("[TB] directed vectors: %0d", vecs.size());
    hi = initWord(32'h200);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      stepDut0(vecs[i], 1'b1, gI, gD);
      if (i == 21) checkOutput("dm_rdata_merge", bif0.dm_rdata, {hi[31:16], 16'hBEEF});
    end

    // STARVE_LIMIT=0 instance: IM always wins when both request.
    $display("[TB] starve-limit-zero sequence");
    prevAddr = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bif1.im_req = 1; bif1.im_addr = 32'h40 + 32'(k) * 4;
      bif1.dm_req = 1; bif1.dm_addr = 32'h500; bif1.dm_web = '0; bif1.dm_wdata = '0;
      stepDut0(idle, 1'b0, gI, gD);
      checkOutput("lim0_im_gnt",    bif1.im_gnt,    1);
      checkOutput("lim0_dm_gnt",    bif1.dm_gnt,    0);
      checkOutput("lim0_sram_addr", bif1.sram_addr, 32'h40 + 32'(k) * 4);
      checkOutput("lim0_im_rvalid", bif1.im_rvalid, (k > 0) ? 1 : 0);
      checkOutput("lim0_dm_rvalid", bif1.dm_rvalid, 0);
      checkOutput("lim0_im_rdata",  bif1.im_rdata,
                  (k > 0) ? (prevAddr ^ 32'h5A5A_5A5A) : 32'h0);
      prevAddr = 32'h40 + 32'(k) * 4;
    end
    @(negedge clk);
    bif1.im_req = 0; bif1.dm_req = 0;
    stepDut0(idle, 1'b0, gI, gD);

    // Random traffic; requests are held until granted, occasionally withdrawn.
    $display("[TB] random traffic");
    v = idle;
    imHeld = 0; dmHeld = 0;
    for (int n = 0; n < 600; n++) begin
      v.rst = ($urandom_range(0, 49) == 0);
      if (!imHeld || $urandom_range(0, 19) == 0) begin
        v.imReq  = ($urandom_range(0, 2) != 0);
        v.imAddr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dmHeld || $urandom_range(0, 19) == 0) begin
        v.dmReq   = ($urandom_range(0, 2) != 0);
        v.dmAddr  = 32'($urandom_range(0, 15)) << 2;
        v.dmWeb   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        v.dmWdata = $urandom;
      end
      @(negedge clk);
      stepDut0(v, 1'b0, gI, gD);
      imHeld = v.imReq && !gI;
      dmHeld = v.dmReq && !gD;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port SRAM between the instruction-fetch requester (IM) and the load/store requester (DM) of the pipelined CPU.
- Grants at most one access per cycle. DM has fixed priority, with an anti-starvation escalation for IM.
- Routes read data back with a 1-cycle registered valid tag to the correct owner.
- Sits between the CPU memory ports and the shared SRAM macro; its grants feed the CPU stall logic.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM port.
- DATA_W, 32, data width; write mask width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive denied IM cycles before IM is promoted above DM. Legal range 0..15; 0 means IM always wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- im_req  input  1  IM access request; held with im_addr until im_gnt.
- im_addr  input  ADDR_W  IM read address.
- im_gnt  output  1  IM request accepted this cycle (combinational).
- im_rvalid  output  1  im_rdata valid (registered, 1 cycle after the IM grant).
- im_rdata  output  DATA_W  IM read data.
- dm_req  input  1  DM access request; held with all dm_* inputs until dm_gnt.
- dm_addr  input  ADDR_W  DM address.
- dm_web  input  DATA_W/8  byte write mask; all zeros means read.
- dm_wdata  input  DATA_W  DM write data.
- dm_gnt  output  1  DM request accepted this cycle (combinational).
- dm_rvalid  output  1  dm_rdata valid (registered, reads only).
- dm_rdata  output  DATA_W  DM read data.
- sram_cs  output  1  SRAM access this cycle.
- sram_addr  output  ADDR_W  SRAM address.
- sram_web  output  DATA_W/8  SRAM byte write mask.
- sram_wdata  output  DATA_W  SRAM write data.
- sram_rdata  input  DATA_W  SRAM read data, valid the cycle after a read access.

Behaviour:
- Registered state:
  - starve_cnt: 4 bits, saturating.
  - rd_owner: 2 bits, one-hot {DM, IM}, marking the read issued last cycle.
- Grant function, evaluated every cycle:
  - im_prio = (starve_cnt >= STARVE_LIMIT).
  - If dm_req && !(im_req && im_prio): dm_gnt=1.
  - Else if im_req: im_gnt=1.
  - Never both grants in one cycle. No requests means no grant and sram_cs=0.
- SRAM drive:
  - sram_cs = im_gnt | dm_gnt.
  - sram_addr/sram_web/sram_wdata are taken from the granted requester.
  - IM grant drives sram_web=0 and sram_wdata=0.
  - With no grant, sram_addr/sram_web/sram_wdata are all zero.
- Read return:
  - Next edge: rd_owner <= {dm_gnt && dm_web==0, im_gnt}.
  - im_rvalid = rd_owner[IM]; dm_rvalid = rd_owner[DM].
  - im_rdata = sram_rdata when im_rvalid, else 0; same rule for dm_rdata.
  - Writes get dm_gnt only, never dm_rvalid.
- Starvation counter, next edge:
  - Cleared to 0 if im_gnt or !im_req.
  - Else incremented when im_req && !im_gnt; saturates at 15.
  - Consequence: after STARVE_LIMIT consecutive denials IM wins exactly one grant, then DM regains priority.
- Back-to-back operation:
  - A grant is possible every cycle, so throughput is 1 access/cycle.
  - A grant in cycle N and a different grant in cycle N+1 are legal; each rvalid tags its own owner.
- Requester deasserts req before grant: legal, nothing issued, starve_cnt clears.
- Reset:
  - At the rst edge, starve_cnt=0 and rd_owner=0, so im_rvalid=dm_rvalid=0 and both rdata outputs are 0.
  - While rst is high, grants are forced to 0 and sram_cs=0.
  - A read granted the cycle before reset produces no rvalid.
- No combinational path from sram_rdata to any grant.

Test Plan:
1. IM-only reads at addr 0x0, 0x4, 0x8 on consecutive cycles.
   - im_gnt=1 each cycle; im_rvalid=1 one cycle later with matching SRAM words; dm_rvalid stays 0.
2. DM read 0x100 and IM read 0x0 requested in the same cycle, STARVE_LIMIT=4.
   - dm_gnt=1, im_gnt=0 in cycle 0; dm_rvalid in cycle 1; IM granted in cycle 1 if DM has dropped its request.
3. DM requests continuously for 10 cycles while IM holds its request.
   - IM is denied cycles 0-3 and granted in cycle 4 (starve_cnt=4).
   - Then 4 more DM grants, with the next IM grant in cycle 9.
4. DM write 0x200, web=4'b0011, wdata=0xDEADBEEF.
   - sram_web=0011, sram_wdata=0xDEADBEEF, dm_gnt=1; no dm_rvalid.
   - A following DM read of 0x200 returns the low half updated.
5. IM read granted in cycle N, rst asserted in cycle N+1.
   - im_rvalid=0 at N+1 onward; starve_cnt=0; no grants while rst=1.
6. STARVE_LIMIT=0 with both requesting every cycle.
   - IM is granted every cycle and DM never; confirms the parameter edge case.
